// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_STORE  = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic int woff_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int line_words, input int num_sets);
        return addr_w - 2 - $clog2(line_words) - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dcache_dm_load_align.sv
// Lane steering: extracts/extends load data and builds store lanes plus byte enables.
module load_align
    import dcache_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [31:0] sdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o,
    output logic [3:0]  be_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (funct3_i)
            F3_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_o = {24'h0, byte_sel};
            F3_LHU:  load_o = {16'h0, half_sel};
            default: load_o = rword_i;
        endcase
        // Store data sits in the low bits; replicate so every candidate lane carries it.
        case (funct3_i[1:0])
            2'b00: begin
                store_o = {4{sdata_i[7:0]}};
                be_o    = 4'b0001 << off_i;
            end
            2'b01: begin
                store_o = {2{sdata_i[15:0]}};
                be_o    = 4'b0011 << {off_i[1], 1'b0};
            end
            default: begin
                store_o = sdata_i;
                be_o    = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache between the Memory stage
// and a word-wide req/ack backing memory.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpu_re_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic [2:0]            cpu_funct3_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int WOB = woff_bits(LINE_WORDS);
    localparam int IB  = index_bits(NUM_SETS);
    localparam int TB  = tag_bits(ADDR_WIDTH, LINE_WORDS, NUM_SETS);
    localparam logic [WOB-1:0] LAST_WORD = WOB'(LINE_WORDS - 1);

    logic [WOB-1:0] woff;
    logic [IB-1:0]  idx;
    logic [TB-1:0]  tag;

    assign woff = cpu_addr_i[2 +: WOB];
    assign idx  = cpu_addr_i[2 + WOB +: IB];
    assign tag  = cpu_addr_i[ADDR_WIDTH-1 -: TB];

    logic [NUM_SETS-1:0]   valid_q, valid_d;
    logic [TB-1:0]         tag_mem  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][LINE_WORDS];

    state_e         state_q, state_d;
    logic [WOB-1:0] cnt_q, cnt_d;
    logic [IB-1:0]  ridx_q, ridx_d;
    logic [TB-1:0]  rtag_q, rtag_d;

    logic        hit;
    logic [31:0] ld_data, st_data;
    logic [3:0]  st_be;
    logic        refill_wr, store_merge;

    assign hit         = valid_q[idx] && (tag_mem[idx] == tag);
    assign refill_wr   = (state_q == ST_REFILL) && mem_ack_i;
    assign store_merge = (state_q == ST_STORE) && mem_ack_i && hit;

    load_align u_align (
        .rword_i  (data_mem[idx][woff]),
        .sdata_i  (cpu_wdata_i),
        .funct3_i (cpu_funct3_i),
        .off_i    (cpu_addr_i[1:0]),
        .load_o   (ld_data),
        .store_o  (st_data),
        .be_o     (st_be)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ridx_q  <= '0;
            rtag_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ridx_q  <= ridx_d;
            rtag_q  <= rtag_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (refill_wr) begin
            data_mem[ridx_q][cnt_q] <= mem_rdata_i;
            if (cnt_q == LAST_WORD) tag_mem[ridx_q] <= rtag_q;
        end
        if (store_merge) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) data_mem[idx][woff][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ridx_d      = ridx_q;
        rtag_d      = rtag_q;
        valid_d     = valid_q;
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        cpu_rdata_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_we_i) begin
                    stall_o = 1'b1;
                    state_d = ST_STORE;
                end else if (cpu_re_i) begin
                    if (hit) begin
                        cpu_rdata_o = ld_data;
                    end else begin
                        stall_o = 1'b1;
                        state_d = ST_REFILL;
                        cnt_d   = '0;
                        ridx_d  = idx;
                        rtag_d  = tag;
                    end
                end
            end
            ST_REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {rtag_q, ridx_q, cnt_q, 2'b00};
                mem_be_o   = 4'hF;
                if (mem_ack_i) begin
                    cnt_d = cnt_q + WOB'(1);
                    if (cnt_q == LAST_WORD) begin
                        valid_d[ridx_q] = 1'b1;
                        state_d         = ST_IDLE;
                    end
                end
            end
            ST_STORE: begin
                // Releasing in the ack cycle lets the store retire without an extra bubble.
                stall_o     = !mem_ack_i;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_o = st_data;
                mem_be_o    = st_be;
                if (mem_ack_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: directed scenarios then randomized traffic vs. a line-level model.
module tb_dcache_dm;

    localparam int LW = 4;
    localparam int NS = 64;
    localparam int LINE_BYTES = LW * 4;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cpu_re_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic [2:0]  cpu_funct3_i;
    logic [31:0] cpu_rdata_o;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    always #5 clk = ~clk;

    dcache_dm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(LW), .NUM_SETS(NS)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cpu_re_i(cpu_re_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_funct3_i(cpu_funct3_i), .cpu_rdata_o(cpu_rdata_o),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    typedef struct {
        bit          is_ld;
        logic [31:0] addr;
        logic [31:0] rdata;
        bit          hit;
        int          nstall;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          checks, errors;
    logic [31:0] mem [int unsigned];
    bit          mv [NS];
    int unsigned mt [NS];
    int          ack_cnt;
    int          max_delay;
    bit          stray_tog;

    function automatic logic [31:0] init_word(input int unsigned wa);
        case (wa)
            32'h40:  return 32'h11;
            32'h41:  return 32'h22;
            32'h42:  return 32'h33;
            32'h43:  return 32'h44;
            32'h80:  return 32'h80FF7F01;
            default: return (wa * 32'h9E3779B1) ^ 32'hC3A55A3C;
        endcase
    endfunction

    function automatic logic [31:0] rd_word(input int unsigned wa);
        if (mem.exists(wa)) return mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return b[7] ? (b | 32'hFFFFFF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Backing memory: acks after a random delay, serves reads from the model memory.
    initial begin : responder
        int wait_n, dly;
        bit stray_seen;
        wait_n = 0; dly = 0; stray_seen = 0; ack_cnt = 0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack_i = 1'b0;
            if (stray_tog != stray_seen) begin
                stray_seen  = stray_tog;
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hBAD0BAD0;
            end else if (rst_ni && mem_req_o) begin
                if (wait_n < dly) wait_n++;
                else begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_we_o ? 32'h0 : rd_word(mem_addr_o >> 2);
                    ack_cnt++;
                    wait_n = 0;
                    dly    = $urandom_range(0, max_delay);
                end
            end
        end
    end

    // Monitor: checks reset outputs, bus transfers, and every released CPU access.
    initial begin : monitor
        exp_t e;
        int   stalls, rf_cnt;
        stalls = 0; rf_cnt = 0; checks = 0; errors = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                chk("rst_ctrl", {29'h0, stall_o, mem_req_o, mem_we_o}, 32'h0);
                chk("rst_mem_addr", mem_addr_o, 32'h0);
                chk("rst_mem_wdata", mem_wdata_o, 32'h0);
                chk("rst_mem_be", {28'h0, mem_be_o}, 32'h0);
                chk("rst_rdata", cpu_rdata_o, 32'h0);
                stalls = 0; rf_cnt = 0;
            end else begin
                if (mem_req_o && mem_ack_i && sb.size() != 0) begin
                    if (sb[0].is_ld) begin
                        chk("refill_addr", mem_addr_o, (sb[0].addr & ~32'(LINE_BYTES - 1)) + 32'(rf_cnt * 4));
                        chk("refill_we", {31'h0, mem_we_o}, 32'h0);
                        rf_cnt++;
                    end else begin
                        chk("st_addr", mem_addr_o, sb[0].addr & ~32'h3);
                        chk("st_we", {31'h0, mem_we_o}, 32'h1);
                        chk("st_be", {28'h0, mem_be_o}, {28'h0, sb[0].be});
                        chk("st_wdata", mem_wdata_o, sb[0].wdata);
                    end
                end
                if (cpu_re_i || cpu_we_i) begin
                    if (stall_o) stalls++;
                    else begin
                        if (sb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL release: got unexpected release at %h expected none", cpu_addr_i);
                        end else begin
                            e = sb.pop_front();
                            if (e.is_ld) begin
                                chk("ld_rdata", cpu_rdata_o, e.rdata);
                                chk("ld_hit", 32'(stalls == 0), 32'(e.hit));
                                if (!e.hit) chk("miss_penalty_min", 32'(stalls >= LW + 1), 32'h1);
                                if (e.nstall >= 0) chk("stall_cycles", 32'(stalls), 32'(e.nstall));
                            end else begin
                                chk("st_stalled", 32'(stalls >= 1), 32'h1);
                            end
                        end
                        stalls = 0; rf_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic drive(input bit re, input bit we, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] d);
        cpu_re_i = re; cpu_we_i = we; cpu_addr_i = a; cpu_funct3_i = f3; cpu_wdata_i = d;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (!stall_o) break;
            if (n > 200) begin
                $display("FAIL timeout: got stall_o held %0d cycles expected release", n);
                $fatal(1, "stall timeout");
            end
        end
        @(posedge clk); #1;
        cpu_re_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input int nst);
        exp_t e;
        int unsigned si, tg;
        si = (a / LINE_BYTES) % NS;
        tg = a / (LINE_BYTES * NS);
        e.is_ld = 1; e.addr = a; e.nstall = nst; e.be = '0; e.wdata = '0;
        e.rdata = ld_ext(rd_word(a >> 2), f3, a[1:0]);
        e.hit   = mv[si] && (mt[si] == tg);
        mv[si] = 1'b1; mt[si] = tg;
        sb.push_back(e);
        drive(1'b1, 1'b0, a, f3, 32'h0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        exp_t e;
        logic [31:0] w;
        e.is_ld = 0; e.addr = a; e.rdata = '0; e.hit = 0; e.nstall = -1;
        case (f3[1:0])
            2'b00:   begin e.be = 4'(1 << a[1:0]);       e.wdata = {4{d[7:0]}};  end
            2'b01:   begin e.be = 4'(3 << (2 * a[1]));   e.wdata = {2{d[15:0]}}; end
            default: begin e.be = 4'hF;                  e.wdata = d;            end
        endcase
        w = rd_word(a >> 2);
        for (int b = 0; b < 4; b++) if (e.be[b]) w[8*b +: 8] = e.wdata[8*b +: 8];
        mem[a >> 2] = w;
        sb.push_back(e);
        drive(1'b0, 1'b1, a, f3, d);
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    initial begin : main
        int base, r;
        logic [31:0] a;
        rst_ni = 1'b0; cpu_re_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0; cpu_funct3_i = 0;
        max_delay = 0; stray_tog = 0;
        for (int i = 0; i < NS; i++) begin mv[i] = 0; mt[i] = 0; end
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        do_load(32'h100, 3'b010, LW + 1);
        do_load(32'h108, 3'b010, 0);

        do_load(32'h200, 3'b010, LW + 1);
        do_load(32'h200, 3'b000, 0);
        do_load(32'h203, 3'b000, 0);
        do_load(32'h203, 3'b100, 0);
        do_load(32'h202, 3'b001, 0);
        do_load(32'h200, 3'b101, 0);

        do_store(32'h201, 3'b000, 32'h000000AB);
        do_load(32'h200, 3'b010, 0);

        do_store(32'h400, 3'b010, 32'hDEADBEEF);
        do_load(32'h400, 3'b010, LW + 1);

        do_load(32'h100, 3'b010, 0);
        do_load(32'h100 + NS * LINE_BYTES, 3'b010, LW + 1);
        do_load(32'h100, 3'b010, LW + 1);

        // Abort a refill halfway with reset; nothing is expected from the aborted load.
        base = ack_cnt;
        cpu_re_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h600; cpu_funct3_i = 3'b010;
        for (int n = 0; ack_cnt < base + 2; n++) begin
            @(posedge clk); #2;
            if (n > 100) begin
                $display("FAIL refill_acks: got %0d acks expected 2", ack_cnt - base);
                $fatal(1, "refill timeout");
            end
        end
        @(posedge clk); #2;
        rst_ni = 1'b0; cpu_re_i = 1'b0;
        for (int i = 0; i < NS; i++) mv[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        do_load(32'h100, 3'b010, LW + 1);

        stray_tog = ~stray_tog;
        idle(3);
        do_load(32'h100, 3'b010, 0);

        max_delay = 3;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            if (r <= 5)      do_load(a, 3'($urandom_range(0, 7)), -1);
            else if (r <= 8) do_store(a, 3'($urandom_range(0, 2)), $urandom);
            else             idle($urandom_range(1, 3));
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
